// File: rtl/fifo_axis_reader_pkg.sv
// fifo_axis_reader_pkg: shared types, constants and helpers for the FIFO-to-AXI4-Stream reader.
package fifo_axis_reader_pkg;

  // Number of words the output buffer can hold.
  localparam int BUF_DEPTH = 2;

  // Widest packet-length input the helper below supports.
  localparam int LEN_MAX_W = 32;

  // Buffer occupancy, 0..BUF_DEPTH.
  typedef logic [1:0] occ_t;

  // A requested packet length of zero means a single-beat packet.
  function automatic logic [LEN_MAX_W-1:0] eff_len(input logic [LEN_MAX_W-1:0] len);
    return (len == '0) ? LEN_MAX_W'(1) : len;
  endfunction

endpackage

// File: rtl/fifo_axis_reader_if.sv
// fifo_axis_reader_if: AXI4-Stream bundle (valid/ready/data/last) with master and slave views.
interface fifo_axis_reader_if #(
  parameter int DATA_W = 32
);

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/fifo_axis_reader_skid_buf.sv
// axis_skid_buf: two-entry circular buffer; the head word is always visible on head_data.
module axis_skid_buf
  import fifo_axis_reader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output occ_t              occ
);

  logic [DATA_W-1:0] mem_reg [BUF_DEPTH];
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  occ_t              occ_reg;
  occ_t              occ_next;

  // Occupancy bookkeeping: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    occ_next = occ_reg;
    case ({push, pop})
      2'b10:   occ_next = occ_reg + occ_t'(1);
      2'b01:   occ_next = occ_reg - occ_t'(1);
      default: occ_next = occ_reg;
    endcase
  end

  // Storage, pointers and count; entries clear on reset so the head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      occ_reg    <= '0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      occ_reg <= occ_next;
    end
  end

  assign head_data = mem_reg[rd_ptr_reg];
  assign occ       = occ_reg;

endmodule

// File: rtl/fifo_axis_reader.sv
// fifo_axis_reader: drains a one-cycle-latency FIFO read port into an AXI4-Stream master,
// framing the stream into packets of pkt_len beats (0 means 1) with tlast.
// Optional: define FIFO_AXIS_READER_STATS_EN to add beat_count / stall_count outputs.
module fifo_axis_reader
  import fifo_axis_reader_pkg::*;
#(
  parameter int FIFO_WIDTH = 32,
  parameter int LEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [LEN_W-1:0]      pkt_len,
  output logic                  rd_cmd,
  input  logic [FIFO_WIDTH-1:0] rd_data,
  input  logic                  empty,
  fifo_axis_reader_if.master    m_axis
`ifdef FIFO_AXIS_READER_STATS_EN
  ,
  output logic [31:0]           beat_count,
  output logic [31:0]           stall_count
`endif
);

  occ_t                  occ;
  logic [FIFO_WIDTH-1:0] head_data;
  logic                  inflight_reg;
  logic [LEN_W-1:0]      beat_cnt_reg;
  logic [LEN_W-1:0]      cur_len_reg;
  logic [LEN_W-1:0]      new_len;
  logic [LEN_W-1:0]      pkt_len_eff;
  logic [2:0]            pending;
  logic                  tvalid;
  logic                  handshake;
  logic                  last_beat;

  axis_skid_buf #(
    .DATA_W (FIFO_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_reg),
    .push_data (rd_data),
    .pop       (handshake),
    .head_data (head_data),
    .occ       (occ)
  );

  assign tvalid    = (occ != '0);
  assign handshake = tvalid & m_axis.tready;

  // Credit: words buffered plus the word in flight may never exceed the buffer depth,
  // except that a handshake this cycle frees a slot for the word requested now.
  assign pending = 3'(occ) + 3'(inflight_reg);
  assign rd_cmd  = rst_n & enable & ~empty & ((pending < 3'(BUF_DEPTH)) | handshake);

  // The first beat of a packet uses the live pkt_len; later beats use the latched length.
  // pkt_len must therefore stay put while a first beat is stalled, or tlast could move.
  assign new_len     = LEN_W'(eff_len(LEN_MAX_W'(pkt_len)));
  assign pkt_len_eff = (beat_cnt_reg == '0) ? new_len : cur_len_reg;
  assign last_beat   = (beat_cnt_reg == pkt_len_eff - LEN_W'(1));

  assign m_axis.tvalid = tvalid;
  assign m_axis.tdata  = head_data;
  assign m_axis.tlast  = tvalid & last_beat;

  // Read-in-flight flag and packet framing counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg <= 1'b0;
      beat_cnt_reg <= '0;
      cur_len_reg  <= '0;
    end else begin
      inflight_reg <= rd_cmd;
      if (handshake) begin
        if (beat_cnt_reg == '0) begin
          cur_len_reg <= new_len;
        end
        beat_cnt_reg <= last_beat ? '0 : beat_cnt_reg + LEN_W'(1);
      end
    end
  end

`ifdef FIFO_AXIS_READER_STATS_EN
  logic [31:0] beat_count_reg;
  logic [31:0] stall_count_reg;

  // Free-running, wrapping counters of accepted beats and stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count_reg  <= '0;
      stall_count_reg <= '0;
    end else begin
      if (handshake) begin
        beat_count_reg <= beat_count_reg + 32'd1;
      end
      if (tvalid && !m_axis.tready) begin
        stall_count_reg <= stall_count_reg + 32'd1;
      end
    end
  end

  assign beat_count  = beat_count_reg;
  assign stall_count = stall_count_reg;
`endif

endmodule
